// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline hazard unit
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } md_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic MD_MUL = 1'b0;
  localparam logic MD_DIV = 1'b1;

endpackage

// File: rtl/md_seq.sv
// rtl/md_seq.sv - multiply/divide sequencer tracking HI/LO busy state
module md_seq
  import pipe_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic op,
  output logic busy,
  output logic done
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

  md_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // RUN lasts LAT cycles (cnt walks LAT-1 down to 0), then one DONE cycle
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          cnt_n   = (op == MD_DIV) ? DIV_LOAD : MUL_LOAD;
          state_n = RUN;
        end
      end
      RUN: begin
        if (cnt == '0) state_n = DONE;
        else           cnt_n   = cnt - CW'(1);
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: rtl/hazard_unit_md.sv
// rtl/hazard_unit_md.sv - forwarding, stall/flush control and mult/div interlock
module hazard_unit_md
  import pipe_pkg::*;
#(
  parameter int REGW    = 5,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNTW    = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [REGW-1:0] rsD,
  input  logic [REGW-1:0] rtD,
  input  logic [REGW-1:0] rsE,
  input  logic [REGW-1:0] rtE,
  input  logic [REGW-1:0] writeregE,
  input  logic [REGW-1:0] writeregM,
  input  logic [REGW-1:0] writeregW,
  input  logic            regwriteE,
  input  logic            regwriteM,
  input  logic            regwriteW,
  input  logic            memtoregE,
  input  logic            memtoregM,
  input  logic            branchD,
  input  logic            mdstartD,
  input  logic            mdstartE,
  input  logic            mdopE,
  input  logic            mfhiloD,
  output logic            stallF,
  output logic            stallD,
  output logic            flushE,
  output logic            forwardAD,
  output logic            forwardBD,
  output logic [1:0]      forwardAE,
  output logic [1:0]      forwardBE,
  output logic            mdbusy,
  output logic            mddone,
  output logic [CNTW-1:0] stall_cnt
);

  // Register 0 is hardwired, so a write to it never produces a dependency
  function automatic logic dep(input logic en, input logic [REGW-1:0] dst,
                               input logic [REGW-1:0] src);
    return en && (dst != '0) && (dst == src);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REGW-1:0] src);
    if (dep(regwriteM, writeregM, src))      return FWD_MEM;
    else if (dep(regwriteW, writeregW, src)) return FWD_WB;
    else                                     return FWD_RF;
  endfunction

  logic lwstall, branchstall, mdstall, stall;

  assign forwardAE = fwd_sel(rsE);
  assign forwardBE = fwd_sel(rtE);
  assign forwardAD = dep(regwriteM, writeregM, rsD);
  assign forwardBD = dep(regwriteM, writeregM, rtD);

  assign lwstall = dep(memtoregE, writeregE, rsD) || dep(memtoregE, writeregE, rtD);

  assign branchstall = branchD &&
                       (dep(regwriteE, writeregE, rsD) || dep(regwriteE, writeregE, rtD) ||
                        dep(memtoregM, writeregM, rsD) || dep(memtoregM, writeregM, rtD));

  md_seq #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_seq (
    .clk   (clk),
    .reset (reset),
    .start (mdstartE),
    .op    (mdopE),
    .busy  (mdbusy),
    .done  (mddone)
  );

  // HI/LO are written at the end of DONE, so readers wait through it too
  assign mdstall = (mfhiloD || mdstartD) && (mdbusy || mdstartE);

  assign stall  = lwstall || branchstall || mdstall;
  assign stallF = stall;
  assign stallD = stall;
  assign flushE = stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         stall_cnt <= '0;
    else if (stall && stall_cnt != '1)  stall_cnt <= stall_cnt + CNTW'(1);
  end

endmodule

// File: tb/tb_hazard_unit_md.sv
// tb/tb_hazard_unit_md.sv - self-checking bench for hazard_unit_md
module tb_hazard_unit_md;

  localparam int REGW    = 5;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [REGW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, branchD;
  logic mdstartD, mdstartE, mdopE, mfhiloD;

  logic stallF_a, stallD_a, flushE_a, forwardAD_a, forwardBD_a, mdbusy_a, mddone_a;
  logic [1:0] forwardAE_a, forwardBE_a;
  logic [15:0] stall_cnt_a;
  logic stallF_b, stallD_b, flushE_b, forwardAD_b, forwardBD_b, mdbusy_b, mddone_b;
  logic [1:0] forwardAE_b, forwardBE_b;
  logic [3:0] stall_cnt_b;

  int n_chk = 0;
  int n_fail = 0;
  int md_rem = 0;
  int m_cnt_a = 0;
  int m_cnt_b = 0;

  always #5 clk = ~clk;

  hazard_unit_md #(.REGW(REGW), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNTW(16)) dut_a (
    .clk(clk), .reset(reset), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM), .branchD(branchD),
    .mdstartD(mdstartD), .mdstartE(mdstartE), .mdopE(mdopE), .mfhiloD(mfhiloD),
    .stallF(stallF_a), .stallD(stallD_a), .flushE(flushE_a),
    .forwardAD(forwardAD_a), .forwardBD(forwardBD_a),
    .forwardAE(forwardAE_a), .forwardBE(forwardBE_a),
    .mdbusy(mdbusy_a), .mddone(mddone_a), .stall_cnt(stall_cnt_a));

  hazard_unit_md #(.REGW(REGW), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNTW(4)) dut_b (
    .clk(clk), .reset(reset), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM), .branchD(branchD),
    .mdstartD(mdstartD), .mdstartE(mdstartE), .mdopE(mdopE), .mfhiloD(mfhiloD),
    .stallF(stallF_b), .stallD(stallD_b), .flushE(flushE_b),
    .forwardAD(forwardAD_b), .forwardBD(forwardBD_b),
    .forwardAE(forwardAE_b), .forwardBE(forwardBE_b),
    .mdbusy(mdbusy_b), .mddone(mddone_b), .stall_cnt(stall_cnt_b));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference rules, evaluated from the current inputs and the model's busy countdown
  function automatic bit hit(input logic en, input logic [REGW-1:0] dst, input logic [REGW-1:0] src);
    return (en === 1'b1) && (dst != 0) && (dst == src);
  endfunction

  function automatic int exp_fwd_e(input logic [REGW-1:0] src);
    if (hit(regwriteM, writeregM, src)) return 2;
    if (hit(regwriteW, writeregW, src)) return 1;
    return 0;
  endfunction

  function automatic bit exp_stall();
    bit lw, br, md;
    lw = hit(memtoregE, writeregE, rsD) || hit(memtoregE, writeregE, rtD);
    br = branchD && (hit(regwriteE, writeregE, rsD) || hit(regwriteE, writeregE, rtD) ||
                     hit(memtoregM, writeregM, rsD) || hit(memtoregM, writeregM, rtD));
    md = (mfhiloD || mdstartD) && (md_rem > 0 || mdstartE);
    return lw || br || md;
  endfunction

  // md_rem counts remaining busy cycles: LAT cycles of work plus the DONE cycle
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_rem  = 0;
      m_cnt_a = 0;
      m_cnt_b = 0;
    end else begin
      if (exp_stall()) begin
        if (m_cnt_a < 65535) m_cnt_a++;
        if (m_cnt_b < 15)    m_cnt_b++;
      end
      if (md_rem > 0)    md_rem--;
      else if (mdstartE) md_rem = (mdopE ? DIV_LAT : MUL_LAT) + 1;
    end
  end

  always @(negedge clk) begin
    check("fwdAE_a", forwardAE_a, exp_fwd_e(rsE));
    check("fwdBE_a", forwardBE_a, exp_fwd_e(rtE));
    check("fwdAD_a", forwardAD_a, hit(regwriteM, writeregM, rsD));
    check("fwdBD_a", forwardBD_a, hit(regwriteM, writeregM, rtD));
    check("stallF_a", stallF_a, exp_stall());
    check("stallD_a", stallD_a, exp_stall());
    check("flushE_a", flushE_a, exp_stall());
    check("mdbusy_a", mdbusy_a, md_rem > 0);
    check("mddone_a", mddone_a, md_rem == 1);
    check("cnt_a", stall_cnt_a, m_cnt_a);
    check("fwdAE_b", forwardAE_b, exp_fwd_e(rsE));
    check("stallF_b", stallF_b, exp_stall());
    check("mdbusy_b", mdbusy_b, md_rem > 0);
    check("mddone_b", mddone_b, md_rem == 1);
    check("cnt_b", stall_cnt_b, m_cnt_b);
    if (mdstartE && reset) check("start_outside_idle", mdbusy_a, 0);
  end

  task automatic clr();
    {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
    {regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, branchD} = '0;
    {mdstartD, mdstartE, mdopE, mfhiloD} = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", mdbusy_a, 0);
    check("rst_done", mddone_a, 0);
    check("rst_cnt", stall_cnt_a, 0);
    check("rst_stall", stallF_a, 0);
    reset = 1'b1;

    rsE = 3; writeregM = 3; regwriteM = 1; writeregW = 3; regwriteW = 1;
    #1 check("fwd_mem", forwardAE_a, 2);
    regwriteM = 0;
    #1 check("fwd_wb", forwardAE_a, 1);
    rsE = 0; writeregM = 0; writeregW = 0; regwriteM = 1;
    #1 check("fwd_r0", forwardAE_a, 0);

    tick(); clr();
    memtoregE = 1; writeregE = 5; rtD = 5;
    #1;
    check("lw_stallF", stallF_a, 1);
    check("lw_stallD", stallD_a, 1);
    check("lw_flushE", flushE_a, 1);
    check("lw_cnt0", stall_cnt_a, 0);
    tick();
    check("lw_cnt1", stall_cnt_a, 1);
    writeregE = 0;
    #1 check("lw_r0", stallF_a, 0);

    clr();
    branchD = 1; rsD = 7; memtoregM = 1; writeregM = 7;
    #1 check("br_load", stallF_a, 1);
    memtoregM = 0; regwriteM = 1;
    #1;
    check("br_alu_stall", stallF_a, 0);
    check("br_alu_fwd", forwardAD_a, 1);

    tick(); clr();
    mdstartE = 1; mdopE = 0; mfhiloD = 1;
    #1;
    check("mul_start_stall", stallF_a, 1);
    check("mul_start_busy", mdbusy_a, 0);
    tick();
    mdstartE = 0;
    for (int k = 1; k <= MUL_LAT + 1; k++) begin
      check("mul_busy", mdbusy_a, 1);
      check("mul_done", mddone_a, k == MUL_LAT + 1);
      check("mul_stall", stallF_a, 1);
      tick();
    end
    check("mul_idle", mdbusy_a, 0);
    check("mul_release", stallF_a, 0);
    check("mul_cnt", stall_cnt_a, 7);
    clr();

    mdstartE = 1; mdopE = 1;
    tick();
    mdstartE = 0;
    repeat (9) @(posedge clk);
    #1 check("div_busy", mdbusy_a, 1);
    reset = 1'b0;
    #1;
    check("div_rst_busy", mdbusy_a, 0);
    check("div_rst_done", mddone_a, 0);
    check("div_rst_cnt", stall_cnt_a, 0);
    tick();
    reset = 1'b1;
    mdstartE = 1; mdopE = 0;
    tick();
    mdstartE = 0;
    for (int k = 1; k <= MUL_LAT + 1; k++) begin
      check("mul2_done", mddone_a, k == MUL_LAT + 1);
      tick();
    end
    check("mul2_idle", mdbusy_a, 0);

    memtoregE = 1; writeregE = 5; rsD = 5;
    repeat (20) @(posedge clk);
    #1;
    check("sat_cnt4", stall_cnt_b, 15);
    check("sat_cnt16", stall_cnt_a, 20);
    clr();

    for (int c = 0; c < 3000; c++) begin
      tick();
      rsD = REGW'($urandom_range(0, 3));
      rtD = REGW'($urandom_range(0, 3));
      rsE = REGW'($urandom_range(0, 3));
      rtE = REGW'($urandom_range(0, 3));
      writeregE = REGW'($urandom_range(0, 3));
      writeregM = REGW'($urandom_range(0, 3));
      writeregW = REGW'($urandom_range(0, 3));
      regwriteE = 1'($urandom_range(0, 1));
      regwriteM = 1'($urandom_range(0, 1));
      regwriteW = 1'($urandom_range(0, 1));
      memtoregE = ($urandom_range(0, 3) == 0);
      memtoregM = ($urandom_range(0, 3) == 0);
      branchD   = ($urandom_range(0, 3) == 0);
      mfhiloD   = ($urandom_range(0, 3) == 0);
      mdstartD  = ($urandom_range(0, 7) == 0);
      mdstartE  = (md_rem == 0) && ($urandom_range(0, 7) == 0);
      mdopE     = ($urandom_range(0, 3) == 0);
      reset     = ($urandom_range(0, 299) != 0);
    end
    tick();
    reset = 1'b1;
    clr();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
